// File: rtl/tile_sched_pkg.sv
// tile_sched_pkg: shared definitions for the tile scheduler.
//   - default widths for the address buses and the tile counter
//   - scheduler state encoding (3 bits)
//   - helper telling whether a state may latch an abort request
package tile_sched_pkg;

  localparam int TS_ADDR_WIDTH_DEF     = 10;
  localparam int TS_TILE_CNT_WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    TS_IDLE   = 3'd0,
    TS_RUN    = 3'd1,
    TS_DRAIN  = 3'd2,
    TS_NEXT   = 3'd3,
    TS_FINISH = 3'd4
  } ts_state_e;

  // Abort is only meaningful while a run is actively stepping through tiles.
  function automatic logic ts_abort_window(input ts_state_e s);
    return (s == TS_RUN) || (s == TS_DRAIN) || (s == TS_NEXT);
  endfunction

endpackage

// File: rtl/tile_sched_addr_gen.sv
// tile_addr_gen: per-operand tile address generator.
//   load      : capture base (as current address) and stride
//   step      : advance the current address by the captured stride
//   base_in   : first-tile address
//   stride_in : per-tile increment
//   addr      : current tile address (registered, wraps modulo 2^ADDR_WIDTH)
module tile_addr_gen
  import tile_sched_pkg::*;
#(
  parameter int ADDR_WIDTH = TS_ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  step,
  input  logic [ADDR_WIDTH-1:0] base_in,
  input  logic [ADDR_WIDTH-1:0] stride_in,
  output logic [ADDR_WIDTH-1:0] addr
);

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;

  // Next address: load wins over step; the add is allowed to wrap.
  always_comb begin
    addr_d   = addr_q;
    stride_d = stride_q;
    if (load) begin
      addr_d   = base_in;
      stride_d = stride_in;
    end else if (step) begin
      addr_d = addr_q + stride_q;
    end else begin
      addr_d   = addr_q;
      stride_d = stride_q;
    end
  end

  // Address and stride registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= '0;
      stride_q <= '0;
    end else begin
      addr_q   <= addr_d;
      stride_q <= stride_d;
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/tile_sched.sv
// tile_sched: runs a programmed number of matmul tiles back-to-back above the
// top-level TPU control. Per tile: present A/B/C addresses, hold start_tpu
// until done_tpu, drop start_tpu, wait for done_tpu to clear.
//   cfg_start / cfg_*   : launch request and layer configuration (latched at launch)
//   abort               : stop request, honoured at the next tile boundary
//   start_tpu, done_tpu : level handshake with the top-level control
//   tile_*_addr, tile_idx : current tile addresses and 0-based index
//   busy, done_all, aborted : run status (done_all is a one-cycle pulse)
module tile_sched
  import tile_sched_pkg::*;
#(
  parameter int ADDR_WIDTH     = TS_ADDR_WIDTH_DEF,
  parameter int TILE_CNT_WIDTH = TS_TILE_CNT_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_start,
  input  logic [TILE_CNT_WIDTH-1:0] cfg_num_tiles,
  input  logic [ADDR_WIDTH-1:0]     cfg_a_base,
  input  logic [ADDR_WIDTH-1:0]     cfg_b_base,
  input  logic [ADDR_WIDTH-1:0]     cfg_c_base,
  input  logic [ADDR_WIDTH-1:0]     cfg_a_stride,
  input  logic [ADDR_WIDTH-1:0]     cfg_b_stride,
  input  logic [ADDR_WIDTH-1:0]     cfg_c_stride,
  input  logic                      abort,
  output logic                      start_tpu,
  input  logic                      done_tpu,
  output logic [ADDR_WIDTH-1:0]     tile_a_addr,
  output logic [ADDR_WIDTH-1:0]     tile_b_addr,
  output logic [ADDR_WIDTH-1:0]     tile_c_addr,
  output logic [TILE_CNT_WIDTH-1:0] tile_idx,
  output logic                      busy,
  output logic                      done_all,
  output logic                      aborted
);

  ts_state_e                 state_q, state_d;
  logic                      start_q, start_d;
  logic                      busy_q, busy_d;
  logic                      done_all_q, done_all_d;
  logic                      aborted_q, aborted_d;
  logic                      abort_lat_q, abort_lat_d;
  logic [TILE_CNT_WIDTH-1:0] idx_q, idx_d;
  logic [TILE_CNT_WIDTH-1:0] num_q, num_d;
  logic                      addr_load_s;
  logic                      addr_step_s;
  logic                      last_tile_s;

  // num_q is never zero while in DRAIN, so the subtraction cannot underflow there.
  assign last_tile_s = (idx_q == (num_q - TILE_CNT_WIDTH'(1)));

  // Next-state and output logic of the tile sequencer.
  always_comb begin
    state_d     = state_q;
    start_d     = start_q;
    busy_d      = busy_q;
    done_all_d  = 1'b0;
    aborted_d   = aborted_q;
    abort_lat_d = abort_lat_q;
    idx_d       = idx_q;
    num_d       = num_q;
    addr_load_s = 1'b0;
    addr_step_s = 1'b0;
    case (state_q)
      TS_IDLE: begin
        // A launch while the lower controller still reports done is dropped.
        if (cfg_start && !done_tpu) begin
          num_d       = cfg_num_tiles;
          aborted_d   = 1'b0;
          abort_lat_d = 1'b0;
          idx_d       = '0;
          busy_d      = 1'b1;
          addr_load_s = 1'b1;
          if (cfg_num_tiles != '0) begin
            start_d = 1'b1;
            state_d = TS_RUN;
          end else begin
            start_d = 1'b0;
            state_d = TS_FINISH;
          end
        end else begin
          start_d = 1'b0;
        end
      end
      TS_RUN: begin
        abort_lat_d = abort_lat_q | abort;
        if (done_tpu) begin
          start_d = 1'b0;
          state_d = TS_DRAIN;
        end else begin
          start_d = 1'b1;
        end
      end
      TS_DRAIN: begin
        abort_lat_d = abort_lat_q | abort;
        start_d     = 1'b0;
        // The stop decision uses the latch as it stood before this cycle.
        if (!done_tpu) begin
          if (last_tile_s || abort_lat_q) begin
            state_d = TS_FINISH;
          end else begin
            idx_d       = idx_q + TILE_CNT_WIDTH'(1);
            addr_step_s = 1'b1;
            state_d     = TS_NEXT;
          end
        end else begin
          state_d = TS_DRAIN;
        end
      end
      TS_NEXT: begin
        // done_tpu is deliberately not looked at here; RUN handles it.
        abort_lat_d = abort_lat_q | abort;
        start_d     = 1'b1;
        state_d     = TS_RUN;
      end
      TS_FINISH: begin
        done_all_d  = 1'b1;
        busy_d      = 1'b0;
        aborted_d   = abort_lat_q;
        abort_lat_d = 1'b0;
        start_d     = 1'b0;
        state_d     = TS_IDLE;
      end
      default: begin
        state_d     = TS_IDLE;
        start_d     = 1'b0;
        busy_d      = 1'b0;
        abort_lat_d = 1'b0;
      end
    endcase
  end

  // Sequencer state and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= TS_IDLE;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_all_q  <= 1'b0;
      aborted_q   <= 1'b0;
      abort_lat_q <= 1'b0;
      idx_q       <= '0;
      num_q       <= '0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      done_all_q  <= done_all_d;
      aborted_q   <= aborted_d;
      abort_lat_q <= abort_lat_d;
      idx_q       <= idx_d;
      num_q       <= num_d;
    end
  end

  tile_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_gen_a (
    .clk      (clk),
    .reset    (reset),
    .load     (addr_load_s),
    .step     (addr_step_s),
    .base_in  (cfg_a_base),
    .stride_in(cfg_a_stride),
    .addr     (tile_a_addr)
  );

  tile_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_gen_b (
    .clk      (clk),
    .reset    (reset),
    .load     (addr_load_s),
    .step     (addr_step_s),
    .base_in  (cfg_b_base),
    .stride_in(cfg_b_stride),
    .addr     (tile_b_addr)
  );

  tile_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_gen_c (
    .clk      (clk),
    .reset    (reset),
    .load     (addr_load_s),
    .step     (addr_step_s),
    .base_in  (cfg_c_base),
    .stride_in(cfg_c_stride),
    .addr     (tile_c_addr)
  );

  assign start_tpu = start_q;
  assign busy      = busy_q;
  assign done_all  = done_all_q;
  assign aborted   = aborted_q;
  assign tile_idx  = idx_q;

endmodule

// File: tb/tb_tile_sched.sv
// tb_tile_sched: self-checking bench for tile_sched.
// A timeline-style reference model (one thread walking through a run) predicts
// every output each cycle; a behavioural TPU model answers start_tpu with
// done_tpu. Directed scenarios pin the model with literal expectations.
module tb_tile_sched;

  localparam int AW   = 10;
  localparam int TW   = 8;
  localparam int MASK = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_start;
  logic [TW-1:0] cfg_num_tiles;
  logic [AW-1:0] cfg_a_base, cfg_b_base, cfg_c_base;
  logic [AW-1:0] cfg_a_stride, cfg_b_stride, cfg_c_stride;
  logic          abort;
  logic          start_tpu;
  logic          done_tpu;
  logic [AW-1:0] tile_a_addr, tile_b_addr, tile_c_addr;
  logic [TW-1:0] tile_idx;
  logic          busy, done_all, aborted;

  int tests = 0;
  int fails = 0;

  // TPU model controls
  int tpu_lat  = 20;
  int tpu_hold = 0;
  bit tpu_force = 1'b0;

  // reference model outputs (valid after the first sampled reset)
  bit m_valid = 1'b0;
  bit m_start, m_busy, m_done_all, m_aborted;
  int m_idx, m_a, m_b, m_c;

  // captures taken at every start_tpu rising edge
  int            rises = 0;
  int            dones = 0;
  logic [AW-1:0] qa[$], qb[$], qc[$];
  int            mqa[$], mqb[$], mqc[$];

  tile_sched dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_start    (cfg_start),
    .cfg_num_tiles(cfg_num_tiles),
    .cfg_a_base   (cfg_a_base),
    .cfg_b_base   (cfg_b_base),
    .cfg_c_base   (cfg_c_base),
    .cfg_a_stride (cfg_a_stride),
    .cfg_b_stride (cfg_b_stride),
    .cfg_c_stride (cfg_c_stride),
    .abort        (abort),
    .start_tpu    (start_tpu),
    .done_tpu     (done_tpu),
    .tile_a_addr  (tile_a_addr),
    .tile_b_addr  (tile_b_addr),
    .tile_c_addr  (tile_c_addr),
    .tile_idx     (tile_idx),
    .busy         (busy),
    .done_all     (done_all),
    .aborted      (aborted)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic tick(output bit r);
    @(posedge clk);
    r = reset;
    m_done_all = 1'b0;
    if (r) begin
      m_valid = 1'b1; m_start = 1'b0; m_busy = 1'b0; m_aborted = 1'b0;
      m_idx = 0; m_a = 0; m_b = 0; m_c = 0;
    end
  endtask

  // One whole run, starting right after the edge that accepted the launch.
  task automatic model_run();
    bit r;
    bit ab;
    int n, k, sa, sb, sc;
    n  = int'(cfg_num_tiles);
    sa = int'(cfg_a_stride); sb = int'(cfg_b_stride); sc = int'(cfg_c_stride);
    m_a = int'(cfg_a_base); m_b = int'(cfg_b_base); m_c = int'(cfg_c_base);
    m_idx = 0; m_busy = 1'b1; m_aborted = 1'b0;
    ab = 1'b0;
    k = 0;
    if (n != 0) begin
      m_start = 1'b1;
      forever begin
        // tile in flight: wait for done
        do begin
          tick(r); if (r) return;
          ab |= abort;
        end while (!done_tpu);
        m_start = 1'b0;
        // wait for done to clear
        forever begin
          tick(r); if (r) return;
          if (!done_tpu) break;
          ab |= abort;
        end
        if (k == n - 1 || ab) begin
          ab |= abort;
          break;
        end
        ab |= abort;
        k++;
        m_idx = k;
        m_a = (m_a + sa) & MASK; m_b = (m_b + sb) & MASK; m_c = (m_c + sc) & MASK;
        // one settle cycle with new addresses, then the next start
        tick(r); if (r) return;
        ab |= abort;
        m_start = 1'b1;
      end
    end
    tick(r); if (r) return;
    m_done_all = 1'b1;
    m_busy     = 1'b0;
    m_aborted  = ab;
  endtask

  initial begin : model_thread
    bit r;
    forever begin
      tick(r);
      if (!r && m_valid && cfg_start && !done_tpu) model_run();
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin : compare_thread
    forever begin
      @(negedge clk);
      if (m_valid) begin
        check("start_tpu", 32'(start_tpu), 32'(m_start));
        check("busy", 32'(busy), 32'(m_busy));
        check("done_all", 32'(done_all), 32'(m_done_all));
        check("aborted", 32'(aborted), 32'(m_aborted));
        check("tile_idx", 32'(tile_idx), 32'(m_idx));
        check("tile_a_addr", 32'(tile_a_addr), 32'(m_a));
        check("tile_b_addr", 32'(tile_b_addr), 32'(m_b));
        check("tile_c_addr", 32'(tile_c_addr), 32'(m_c));
      end
    end
  end

  // TPU model: done rises tpu_lat cycles after start, falls tpu_hold+1 cycles after start drops.
  initial begin : tpu_thread
    int cnt;
    int hold_cnt;
    cnt = 0;
    hold_cnt = 0;
    done_tpu = 1'b0;
    forever begin
      @(negedge clk);
      if (tpu_force) begin
        done_tpu = 1'b1;
      end else if (start_tpu === 1'b1) begin
        cnt++;
        if (cnt >= tpu_lat) done_tpu = 1'b1;
        hold_cnt = tpu_hold;
      end else begin
        cnt = 0;
        if (done_tpu && hold_cnt > 0) hold_cnt--;
        else done_tpu = 1'b0;
      end
    end
  end

  // Capture addresses at each start_tpu rise, and count done_all pulses.
  initial begin : capture_thread
    logic prev;
    prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (start_tpu === 1'b1 && !prev) begin
        rises++;
        qa.push_back(tile_a_addr); qb.push_back(tile_b_addr); qc.push_back(tile_c_addr);
        mqa.push_back(m_a); mqb.push_back(m_b); mqc.push_back(m_c);
      end
      prev = (start_tpu === 1'b1);
      if (done_all === 1'b1) dones++;
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_caps();
    rises = 0; dones = 0;
    qa.delete(); qb.delete(); qc.delete();
    mqa.delete(); mqb.delete(); mqc.delete();
  endtask

  task automatic set_cfg(input int n, input int ab, input int bb, input int cb,
                         input int as, input int bs, input int cs);
    cfg_num_tiles = TW'(n);
    cfg_a_base = AW'(ab); cfg_b_base = AW'(bb); cfg_c_base = AW'(cb);
    cfg_a_stride = AW'(as); cfg_b_stride = AW'(bs); cfg_c_stride = AW'(cs);
  endtask

  task automatic pulse_start();
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int c;
    c = 0;
    while (done_all !== 1'b1 && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(nm, 32'(done_all), 32'd1);
  endtask

  task automatic wait_rises(input string nm, input int target, input int budget);
    int c;
    c = 0;
    while (rises < target && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(nm, 32'(rises), 32'(target));
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    logic [AW-1:0] exp_a[3];
    logic [AW-1:0] exp_b[3];
    logic [AW-1:0] exp_c[3];
    int c;
    exp_a = '{10'h000, 10'h010, 10'h020};
    exp_b = '{10'h100, 10'h120, 10'h140};
    exp_c = '{10'h200, 10'h240, 10'h280};

    reset = 1'b1; cfg_start = 1'b0; abort = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_start", 32'(start_tpu), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done_all", 32'(done_all), 32'd0);
    check("rst_aborted", 32'(aborted), 32'd0);
    check("rst_idx", 32'(tile_idx), 32'd0);
    check("rst_addr", 32'({tile_a_addr, tile_b_addr, tile_c_addr}), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // three tiles, fixed TPU latency
    clear_caps();
    tpu_lat = 20; tpu_hold = 0;
    set_cfg(3, 'h000, 'h100, 'h200, 'h010, 'h020, 'h040);
    pulse_start();
    check("launch_start_hi", 32'(start_tpu), 32'd1);
    wait_done("three_done", 400);
    check("three_busy_low_with_done", 32'(busy), 32'd0);
    check("three_rises", 32'(rises), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("three_a%0d", i), 32'(qa[i]), 32'(exp_a[i]));
      check($sformatf("three_b%0d", i), 32'(qb[i]), 32'(exp_b[i]));
      check($sformatf("three_c%0d", i), 32'(qc[i]), 32'(exp_c[i]));
      check($sformatf("model_a%0d", i), 32'(mqa[i]), 32'(exp_a[i]));
      check($sformatf("model_b%0d", i), 32'(mqb[i]), 32'(exp_b[i]));
      check($sformatf("model_c%0d", i), 32'(mqc[i]), 32'(exp_c[i]));
    end
    repeat (3) @(negedge clk);
    check("three_done_once", 32'(dones), 32'd1);
    check("hold_addr_a", 32'(tile_a_addr), 32'h020);

    // zero tiles
    clear_caps();
    set_cfg(0, 'h055, 'h066, 'h077, 1, 1, 1);
    pulse_start();
    check("zero_busy_c1", 32'(busy), 32'd1);
    check("zero_done_c1", 32'(done_all), 32'd0);
    @(negedge clk);
    check("zero_busy_c2", 32'(busy), 32'd0);
    check("zero_done_c2", 32'(done_all), 32'd1);
    check("zero_rises", 32'(rises), 32'd0);
    repeat (2) @(negedge clk);

    // address wrap
    clear_caps();
    tpu_lat = 4;
    set_cfg(2, 'h3F0, 'h000, 'h000, 'h020, 'h001, 'h002);
    pulse_start();
    wait_done("wrap_done", 200);
    check("wrap_a0", 32'(qa[0]), 32'h3F0);
    check("wrap_a1", 32'(qa[1]), 32'h010);
    check("model_wrap_a1", 32'(mqa[1]), 32'h010);
    repeat (2) @(negedge clk);

    // abort during tile 1
    clear_caps();
    tpu_lat = 20;
    set_cfg(5, 'h000, 'h000, 'h000, 'h004, 'h008, 'h00C);
    pulse_start();
    wait_rises("abort_reach_t1", 2, 200);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done("abort_done", 400);
    check("abort_rises", 32'(rises), 32'd2);
    check("abort_flag", 32'(aborted), 32'd1);
    check("model_abort_flag", 32'(m_aborted), 32'd1);
    @(negedge clk);
    clear_caps();
    set_cfg(1, 'h010, 'h020, 'h030, 0, 0, 0);
    pulse_start();
    check("relaunch_clears_aborted", 32'(aborted), 32'd0);
    wait_done("relaunch_done", 200);
    check("relaunch_rises", 32'(rises), 32'd1);
    repeat (2) @(negedge clk);

    // launch dropped while done_tpu is high
    tpu_force = 1'b1;
    repeat (2) @(negedge clk);
    set_cfg(2, 0, 0, 0, 1, 1, 1);
    pulse_start();
    check("drop_busy", 32'(busy), 32'd0);
    check("drop_start", 32'(start_tpu), 32'd0);
    tpu_force = 1'b0;
    repeat (3) @(negedge clk);

    // re-launch while busy, then reset in DRAIN of tile 1
    clear_caps();
    set_cfg(4, 'h100, 'h100, 'h100, 'h001, 'h001, 'h001);
    pulse_start();
    repeat (5) @(negedge clk);
    set_cfg(7, 'h3FF, 'h3FF, 'h3FF, 'h0FF, 'h0FF, 'h0FF);
    pulse_start();
    wait_rises("rst_reach_t1", 2, 200);
    c = 0;
    while (start_tpu !== 1'b0 && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("rst_reach_drain", 32'(start_tpu), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_start", 32'(start_tpu), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_idx", 32'(tile_idx), 32'd0);
    check("midrst_rises", 32'(rises), 32'd2);
    @(negedge clk);
    clear_caps();
    tpu_lat = 3;
    set_cfg(2, 'h040, 'h080, 'h0C0, 'h100, 'h100, 'h100);
    pulse_start();
    wait_done("post_rst_done", 200);
    check("post_rst_rises", 32'(rises), 32'd2);
    check("post_rst_c1", 32'(qc[1]), 32'h1C0);
    repeat (2) @(negedge clk);

    // randomized runs checked cycle by cycle against the model
    for (int it = 0; it < 30; it++) begin
      tpu_lat  = int'($urandom_range(1, 25));
      tpu_hold = int'($urandom_range(0, 2));
      set_cfg(int'($urandom_range(0, 6)), int'($urandom), int'($urandom), int'($urandom),
              int'($urandom), int'($urandom), int'($urandom));
      pulse_start();
      c = 0;
      while (done_all !== 1'b1 && c < 3000) begin
        abort     = ($urandom_range(0, 59) == 0);
        cfg_start = ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, 9) == 0)
          set_cfg(int'($urandom_range(0, 9)), int'($urandom), int'($urandom), int'($urandom),
                  int'($urandom), int'($urandom), int'($urandom));
        @(negedge clk);
        c++;
      end
      abort = 1'b0;
      cfg_start = 1'b0;
      check($sformatf("rand_done_%0d", it), 32'(done_all), 32'd1);
      repeat (int'($urandom_range(1, 3))) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
